spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Shares the single RAM command port between two requesters: requester A (SPI slave) and requester B (local host/BIST).
- Each requester issues 10-bit RAM commands {cmd[1:0], payload[MEM_WIDTH-1:0]}.
- The RAM keeps address state between commands, so the block round-robins at command-pair boundaries and locks ownership from an address command until its matching data command and read response.
- Sits between the SPI slave/host and the RAM; it replaces the direct rx_data/rx_valid wiring.

Parameters:
- MEM_WIDTH, 8, RAM data width; commands are MEM_WIDTH+2 bits wide.
- LOCK_TIMEOUT, 64, cycles an owner may hold a lock without progress before forced release.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_rx_data  in  MEM_WIDTH+2  requester A command.
- a_rx_valid  in  1  A command valid; held until accepted.
- a_ready  out  1  A command accepted this cycle when a_rx_valid && a_ready.
- a_tx_valid  out  1  read data valid for A.
- b_rx_data, b_rx_valid, b_ready, b_tx_valid: same as A, for requester B.
- tx_data  out  MEM_WIDTH  read data broadcast to both requesters; qualify with x_tx_valid.
- ram_rx_data  out  MEM_WIDTH+2  command to RAM (registered).
- ram_rx_valid  out  1  one-cycle command strobe to RAM.
- ram_dout  in  MEM_WIDTH  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.
- owner  out  1  current or last grantee (0=A, 1=B).
- busy  out  1  state != ARB_IDLE.
- proto_err  out  1  one-cycle pulse on an out-of-sequence command.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset values:
  - All outputs 0, state ARB_IDLE, timer 0.
  - last_grant = B, so A wins the first tie.
  - Reset mid-transaction discards the lock and any pending command.
- Commands: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- Acceptance:
  - A command is accepted at edge N when rx_valid && ready.
  - At N+1, ram_rx_data = accepted word and ram_rx_valid = 1 for exactly one cycle.
  - Back-to-back acceptance is allowed.
  - ready is combinational from state, grant and rx_valid.
- ARB_IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester != last_grant.
  - The grantee's ready = 1; the other's ready = 0. owner and last_grant update on accept.
  - Next state by accepted cmd:
    - 00 -> ARB_LOCK_WR.
    - 10 -> ARB_LOCK_RD.
    - 11 -> ARB_WAIT_TX, with proto_err.
    - 01 -> stays ARB_IDLE, with proto_err. The command is still forwarded.
- ARB_LOCK_WR / ARB_LOCK_RD:
  - Only the owner's ready may be 1; the non-owner is stalled.
  - Next state by accepted owner cmd:
    - 01 -> ARB_IDLE.
    - 11 -> ARB_WAIT_TX.
    - 00 -> ARB_LOCK_WR.
    - 10 -> ARB_LOCK_RD.
  - proto_err pulses when cmd is not the expected one: 01 in LOCK_WR, 11 in LOCK_RD. Every accepted command is forwarded.
- ARB_WAIT_TX:
  - Both ready = 0.
  - On ram_tx_valid: owner's x_tx_valid = 1 in the same cycle (combinational route), tx_data = ram_dout, then -> ARB_IDLE.
  - The non-owner's tx_valid is never asserted.
- ram_tx_valid outside ARB_WAIT_TX is ignored; neither tx_valid asserts.
- Timer:
  - Clears on every state entry and on every accepted command.
  - Increments each cycle in a non-IDLE state.
  - When the timer reaches LOCK_TIMEOUT-1 without progress: -> ARB_IDLE, timeout pulses for one cycle, and last_grant = owner so the other requester wins next.
  - Width is $clog2(LOCK_TIMEOUT+1).
- Simultaneous events:
  - Timer expiry in the same cycle as an accepted command: the command wins.
  - ram_tx_valid in the same cycle as expiry in WAIT_TX: the data is delivered.

Decomposition:
- shared_pkg gains:
  - ram_cmd_e {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA}.
  - arb_state_e {ARB_IDLE, ARB_LOCK_WR, ARB_LOCK_RD, ARB_WAIT_TX}, prefixed to avoid clashing with the slave FSM names.
  - LOCK_TIMEOUT default.
- One sub-module, rr_pick2: 2-way round-robin grant from valids and last_grant. Timer and FSM stay inline.
- SPI_if gains an arbiter modport.

Test Plan:
- Reset, then A sends 10'h03C, then 10'h1A5 -> ram_rx_data 03C then 1A5, each one cycle after accept; busy 1 between; ends ARB_IDLE; proto_err 0.
- A and B both valid with 10'h011 / 10'h022 at reset exit -> A granted first. B stalls (b_ready 0) until A's 10'h1xx completes, then B's 10'h022 is forwarded.
- A sends 10'h210, then 10'h300; RAM returns ram_dout 8'h5A with ram_tx_valid 2 cycles later -> a_tx_valid 1 for one cycle, tx_data 5A, b_tx_valid 0.
- A sends 10'h010 then idles (LOCK_TIMEOUT=8) -> timeout pulse 8 cycles after lock; a pending B request is granted the next cycle.
- A sends 10'h1FF in ARB_IDLE -> forwarded, proto_err pulse, state stays ARB_IDLE. A sends 10'h300 in ARB_LOCK_WR -> proto_err, -> ARB_WAIT_TX.
- rst_n low for 1 cycle in ARB_WAIT_TX -> all outputs 0 immediately; a late ram_tx_valid is ignored.

Source files
------------

// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types for the SPI/host RAM command arbiter: RAM command codes,
// arbiter states and the command-sequence rule used for protocol checking.
package spi_ram_arbiter_pkg;

    localparam int MEM_WIDTH_DEFAULT    = 8;
    localparam int LOCK_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } ram_cmd_e;

    // Prefixed so they do not collide with the SPI slave FSM state names.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOCK_WR,
        ARB_LOCK_RD,
        ARB_WAIT_TX
    } arb_state_e;

    function automatic logic cmd_in_sequence(input arb_state_e st, input ram_cmd_e cmd);
        case (st)
            ARB_IDLE:    return (cmd == WR_ADDR) || (cmd == RD_ADDR);
            ARB_LOCK_WR: return cmd == WR_DATA;
            ARB_LOCK_RD: return cmd == RD_DATA;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the one that
// was not granted last time wins.
module rr_pick2 (
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic last_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    assign gnt_a_o = req_a_i && (!req_b_i || last_b_i);
    assign gnt_b_o = req_b_i && (!req_a_i || !last_b_i);

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares the RAM command port between requester A (SPI slave) and B (host),
// locking ownership from an address command until its data command/read response.
module spi_ram_arbiter
    import spi_ram_arbiter_pkg::*;
#(
    parameter int MEM_WIDTH    = MEM_WIDTH_DEFAULT,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEM_WIDTH+1:0] a_rx_data,
    input  logic                 a_rx_valid,
    output logic                 a_ready,
    output logic                 a_tx_valid,
    input  logic [MEM_WIDTH+1:0] b_rx_data,
    input  logic                 b_rx_valid,
    output logic                 b_ready,
    output logic                 b_tx_valid,
    output logic [MEM_WIDTH-1:0] tx_data,
    output logic [MEM_WIDTH+1:0] ram_rx_data,
    output logic                 ram_rx_valid,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 owner,
    output logic                 busy,
    output logic                 proto_err,
    output logic                 timeout
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_b_q, last_b_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [MEM_WIDTH+1:0] ram_rx_data_q, ram_rx_data_d;
    logic                 ram_rx_valid_q, ram_rx_valid_d;
    logic                 proto_err_q, proto_err_d;
    logic                 timeout_q, timeout_d;

    logic                 pick_a, pick_b;
    logic                 accept, accept_b, deliver;
    logic [MEM_WIDTH+1:0] acc_word;
    ram_cmd_e             acc_cmd;

    rr_pick2 u_pick (
        .req_a_i  (a_rx_valid),
        .req_b_i  (b_rx_valid),
        .last_b_i (last_b_q),
        .gnt_a_o  (pick_a),
        .gnt_b_o  (pick_b)
    );

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                a_ready = pick_a;
                b_ready = pick_b;
            end
            ARB_LOCK_WR, ARB_LOCK_RD: begin
                a_ready = a_rx_valid && !owner_q;
                b_ready = b_rx_valid && owner_q;
            end
            default: ;
        endcase
    end

    assign accept_b = b_rx_valid && b_ready;
    assign accept   = (a_rx_valid && a_ready) || accept_b;
    assign acc_word = accept_b ? b_rx_data : a_rx_data;
    assign acc_cmd  = ram_cmd_e'(acc_word[MEM_WIDTH+1 -: 2]);

    // Read data is routed straight through so the owner sees it in the RAM's cycle.
    assign deliver    = (state_q == ARB_WAIT_TX) && ram_tx_valid;
    assign a_tx_valid = deliver && !owner_q;
    assign b_tx_valid = deliver && owner_q;
    assign tx_data    = deliver ? ram_dout : '0;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_b_d       = last_b_q;
        timer_d        = '0;
        ram_rx_data_d  = ram_rx_data_q;
        ram_rx_valid_d = 1'b0;
        proto_err_d    = 1'b0;
        timeout_d      = 1'b0;

        // Priority: accepted command, then read delivery, then lock expiry.
        if (accept) begin
            owner_d        = accept_b;
            last_b_d       = accept_b;
            ram_rx_data_d  = acc_word;
            ram_rx_valid_d = 1'b1;
            proto_err_d    = !cmd_in_sequence(state_q, acc_cmd);
            case (acc_cmd)
                WR_ADDR: state_d = ARB_LOCK_WR;
                RD_ADDR: state_d = ARB_LOCK_RD;
                RD_DATA: state_d = ARB_WAIT_TX;
                default: state_d = ARB_IDLE;
            endcase
        end else if (deliver) begin
            state_d = ARB_IDLE;
        end else if (state_q != ARB_IDLE) begin
            if (timer_q == TIMER_LAST) begin
                state_d   = ARB_IDLE;
                timeout_d = 1'b1;
                last_b_d  = owner_q;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            owner_q        <= 1'b0;
            last_b_q       <= 1'b1;
            timer_q        <= '0;
            ram_rx_data_q  <= '0;
            ram_rx_valid_q <= 1'b0;
            proto_err_q    <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_b_q       <= last_b_d;
            timer_q        <= timer_d;
            ram_rx_data_q  <= ram_rx_data_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            proto_err_q    <= proto_err_d;
            timeout_q      <= timeout_d;
        end
    end

    assign ram_rx_data  = ram_rx_data_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign owner        = owner_q;
    assign busy         = (state_q != ARB_IDLE);
    assign proto_err    = proto_err_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: reset, a cycle table, corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_spi_ram_arbiter;

    localparam int MW = 8;
    localparam int LT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [MW+1:0] a_rx_data, b_rx_data;
    logic          a_rx_valid, b_rx_valid;
    logic          a_ready, b_ready, a_tx_valid, b_tx_valid;
    logic [MW-1:0] tx_data;
    logic [MW+1:0] ram_rx_data;
    logic          ram_rx_valid;
    logic [MW-1:0] ram_dout;
    logic          ram_tx_valid;
    logic          owner, busy, proto_err, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.MEM_WIDTH(MW), .LOCK_TIMEOUT(LT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_rx_data    (a_rx_data),
        .a_rx_valid   (a_rx_valid),
        .a_ready      (a_ready),
        .a_tx_valid   (a_tx_valid),
        .b_rx_data    (b_rx_data),
        .b_rx_valid   (b_rx_valid),
        .b_ready      (b_ready),
        .b_tx_valid   (b_tx_valid),
        .tx_data      (tx_data),
        .ram_rx_data  (ram_rx_data),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .owner        (owner),
        .busy         (busy),
        .proto_err    (proto_err),
        .timeout      (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic av; logic [9:0] ad; logic bv; logic [9:0] bd; logic rtv; logic [7:0] dout;
        logic e_ar; logic e_br; logic e_rv; logic [9:0] e_rd; logic e_perr; logic e_busy;
        logic e_own; logic e_atx; logic e_btx; logic [7:0] e_tx;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(
        input logic av, input logic [9:0] ad, input logic bv, input logic [9:0] bd,
        input logic rtv, input logic [7:0] dout,
        input logic ar, input logic br, input logic rv, input logic [9:0] rd,
        input logic perr, input logic bsy, input logic own,
        input logic atx, input logic btx, input logic [7:0] tx);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.rtv = rtv; v.dout = dout;
        v.e_ar = ar; v.e_br = br; v.e_rv = rv; v.e_rd = rd; v.e_perr = perr;
        v.e_busy = bsy; v.e_own = own; v.e_atx = atx; v.e_btx = btx; v.e_tx = tx;
        return v;
    endfunction

    task automatic send(input bit side_b, input logic [9:0] w);
        bit ok;
        ok = 1'b0;
        if (side_b) begin b_rx_valid = 1'b1; b_rx_data = w; end
        else begin a_rx_valid = 1'b1; a_rx_data = w; end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = side_b ? b_ready : a_ready;
            @(posedge clk); #1;
        end
        if (side_b) b_rx_valid = 1'b0; else a_rx_valid = 1'b0;
        check("send_accept", {31'd0, ok}, 32'd1);
        $display("send %s %03h accepted=%0d", side_b ? "B" : "A", w, ok);
    endtask

    // Reference model: a requester holds a lock from an address command until
    // the following data command; the read data command then waits for the RAM.
    int            m_mode;   // 0 free, 1 write-addressed, 2 read-addressed, 3 awaiting read data
    int            m_owner, m_last, m_idle;
    logic          m_rv, m_perr, m_tout;
    logic [9:0]    m_rd;
    int            next_mode [4] = '{1, 0, 2, 3};

    initial begin
        logic          pa_v, pb_v, e_ar, e_br, deliv, e_atx, e_btx, seen;
        logic [9:0]    pa_d, pb_d, word;
        logic [7:0]    e_tx;
        int            winner, cmd, edges;

        a_rx_valid = 0; b_rx_valid = 0; a_rx_data = '0; b_rx_data = '0;
        ram_tx_valid = 0; ram_dout = '0;

        // ---- reset ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {a_ready, b_ready}, 0);
        check("rst_tx", {a_tx_valid, b_tx_valid, tx_data}, 0);
        check("rst_ram", {ram_rx_valid, ram_rx_data}, 0);
        check("rst_status", {owner, busy, proto_err, timeout}, 0);
        $display("reset checked");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- table: tie at reset exit, stall, write pair, protocol errors, read ----
        vecs[0]  = mk(1, 10'h011, 1, 10'h022, 0, 8'h00, 1, 0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00);
        vecs[1]  = mk(1, 10'h1AA, 1, 10'h022, 0, 8'h00, 1, 0, 1, 10'h011, 0, 1, 0, 0, 0, 8'h00);
        vecs[2]  = mk(0, 10'h000, 1, 10'h022, 0, 8'h00, 0, 1, 1, 10'h1AA, 0, 0, 0, 0, 0, 8'h00);
        vecs[3]  = mk(1, 10'h03C, 0, 10'h000, 0, 8'h00, 0, 0, 1, 10'h022, 0, 1, 1, 0, 0, 8'h00);
        vecs[4]  = mk(1, 10'h03C, 1, 10'h155, 0, 8'h00, 0, 1, 0, 10'h022, 0, 1, 1, 0, 0, 8'h00);
        vecs[5]  = mk(1, 10'h03C, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h155, 0, 0, 1, 0, 0, 8'h00);
        vecs[6]  = mk(1, 10'h1A5, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h03C, 0, 1, 0, 0, 0, 8'h00);
        vecs[7]  = mk(1, 10'h1FF, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h1A5, 0, 0, 0, 0, 0, 8'h00);
        vecs[8]  = mk(1, 10'h010, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h1FF, 1, 0, 0, 0, 0, 8'h00);
        vecs[9]  = mk(1, 10'h300, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h010, 0, 1, 0, 0, 0, 8'h00);
        vecs[10] = mk(0, 10'h000, 0, 10'h000, 1, 8'h77, 0, 0, 1, 10'h300, 1, 1, 0, 1, 0, 8'h77);
        vecs[11] = mk(0, 10'h000, 0, 10'h000, 1, 8'h66, 0, 0, 0, 10'h300, 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 12; i++) begin
            a_rx_valid = vecs[i].av; a_rx_data = vecs[i].ad;
            b_rx_valid = vecs[i].bv; b_rx_data = vecs[i].bd;
            ram_tx_valid = vecs[i].rtv; ram_dout = vecs[i].dout;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {a_ready, b_ready}, {vecs[i].e_ar, vecs[i].e_br});
            check($sformatf("vec%0d_ram", i), {ram_rx_valid, ram_rx_data}, {vecs[i].e_rv, vecs[i].e_rd});
            check($sformatf("vec%0d_status", i), {owner, busy, proto_err},
                  {vecs[i].e_own, vecs[i].e_busy, vecs[i].e_perr});
            check($sformatf("vec%0d_tx", i), {a_tx_valid, b_tx_valid, tx_data},
                  {vecs[i].e_atx, vecs[i].e_btx, vecs[i].e_tx});
            $display("vec %0d a=%b/%03h b=%b/%03h ram=%b/%03h", i, a_rx_valid, a_rx_data,
                     b_rx_valid, b_rx_data, ram_rx_valid, ram_rx_data);
            @(posedge clk); #1;
        end
        a_rx_valid = 0; b_rx_valid = 0; ram_tx_valid = 0;

        // ---- read response two cycles after the read data command ----
        send(0, 10'h210);
        send(0, 10'h300);
        @(negedge clk);
        check("rd_wait_busy", {busy, a_ready, a_tx_valid}, 3'b100);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        ram_tx_valid = 1; ram_dout = 8'h5A;
        @(negedge clk);
        check("rd_deliver", {a_tx_valid, b_tx_valid, tx_data}, {2'b10, 8'h5A});
        $display("read delivered a_tx=%b tx_data=%02h", a_tx_valid, tx_data);
        @(posedge clk); #1;
        ram_tx_valid = 0;
        @(negedge clk);
        check("rd_after", {busy, a_tx_valid}, 0);
        @(posedge clk); #1;

        // ---- lock timeout with B waiting ----
        send(0, 10'h010);
        b_rx_valid = 1; b_rx_data = 10'h0AB;
        edges = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (timeout) seen = 1;
            else begin
                check("lock_stall_b", {31'd0, b_ready}, 0);
                @(posedge clk); #1;
                edges++;
            end
        end
        check("timeout_seen", {31'd0, seen}, 1);
        check("timeout_latency", edges, LT);
        check("timeout_b_grant", {b_ready, busy}, 2'b10);
        $display("timeout after %0d cycles b_ready=%b", edges, b_ready);
        @(posedge clk); #1;
        b_rx_valid = 0;
        @(negedge clk);
        check("timeout_width", {31'd0, timeout}, 0);
        check("timeout_b_fwd", {ram_rx_valid, ram_rx_data, owner}, {1'b1, 10'h0AB, 1'b1});
        @(posedge clk); #1;
        send(1, 10'h1CD);

        // ---- reset while waiting for read data ----
        send(0, 10'h210);
        send(0, 10'h300);
        @(negedge clk);
        check("prerst_busy", {31'd0, busy}, 1);
        rst_n = 0;
        #1;
        check("midrst_out", {busy, ram_rx_valid, ram_rx_data, owner, proto_err, timeout}, 0);
        ram_tx_valid = 1; ram_dout = 8'hC3;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("late_rtv_ignored", {a_tx_valid, b_tx_valid, tx_data, busy}, 0);
        $display("reset in WAIT_TX, late data ignored");
        @(posedge clk); #1;
        ram_tx_valid = 0;

        // ---- randomized traffic vs reference model ----
        m_mode = 0; m_owner = 0; m_last = 1; m_idle = 0;
        m_rv = 0; m_perr = 0; m_tout = 0; m_rd = '0;
        pa_v = 0; pb_v = 0; pa_d = '0; pb_d = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!pa_v && $urandom_range(0, 3) == 0) begin pa_v = 1; pa_d = 10'($urandom_range(0, 1023)); end
            if (!pb_v && $urandom_range(0, 3) == 0) begin pb_v = 1; pb_d = 10'($urandom_range(0, 1023)); end
            a_rx_valid = pa_v; a_rx_data = pa_d;
            b_rx_valid = pb_v; b_rx_data = pb_d;
            ram_tx_valid = ($urandom_range(0, 5) == 0);
            ram_dout = 8'($urandom);
            @(negedge clk);

            e_ar = 0; e_br = 0;
            if (m_mode == 0) begin
                if (pa_v && pb_v) winner = 1 - m_last;
                else winner = pa_v ? 0 : 1;
                e_ar = pa_v && (winner == 0);
                e_br = pb_v && (winner == 1);
            end else if (m_mode != 3) begin
                e_ar = pa_v && (m_owner == 0);
                e_br = pb_v && (m_owner == 1);
            end
            deliv = (m_mode == 3) && ram_tx_valid;
            e_atx = deliv && (m_owner == 0);
            e_btx = deliv && (m_owner == 1);
            e_tx  = deliv ? ram_dout : 8'h00;

            check("rand_ready", {a_ready, b_ready}, {e_ar, e_br});
            check("rand_tx", {a_tx_valid, b_tx_valid, tx_data}, {e_atx, e_btx, e_tx});
            check("rand_ram", {ram_rx_valid, ram_rx_data}, {m_rv, m_rd});
            check("rand_status", {owner, busy, proto_err, timeout},
                  {m_owner[0], (m_mode != 0), m_perr, m_tout});

            @(posedge clk);
            m_rv = 0; m_perr = 0; m_tout = 0;
            if (e_ar || e_br) begin
                word = e_br ? pb_d : pa_d;
                cmd  = int'(word[9:8]);
                m_rv = 1; m_rd = word;
                m_owner = e_br ? 1 : 0;
                m_last  = m_owner;
                if (m_mode == 0) m_perr = (cmd % 2 == 1);
                else if (m_mode == 1) m_perr = (cmd != 1);
                else m_perr = (cmd != 3);
                m_mode = next_mode[cmd];
                m_idle = 0;
                if (e_br) pb_v = 0; else pa_v = 0;
                $display("rand cyc %0d fwd %s %03h", cyc, e_br ? "B" : "A", word);
            end else if (deliv) begin
                m_mode = 0; m_idle = 0;
            end else if (m_mode != 0) begin
                m_idle++;
                if (m_idle == LT) begin m_mode = 0; m_tout = 1; m_idle = 0; end
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
